// File: rtl/counter_pkg.sv
// counter_pkg -- constants shared by the modulo-N digit counter slice.
//   DEFAULT_WIDTH / DEFAULT_MODULUS : one BCD digit out of the box
//   BCD_MODULUS / HEX_MODULUS       : common digit radices
//   UP / DOWN                       : encoding of the Up direction input
package counter_pkg;

   localparam int   DEFAULT_WIDTH   = 4;
   localparam int   DEFAULT_MODULUS = 10;
   localparam int   BCD_MODULUS     = 10;
   localparam int   HEX_MODULUS     = 16;

   localparam logic UP   = 1'b1;
   localparam logic DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/mod_next.sv
// mod_next -- combinational next-value generator for a modulo-N digit.
//   q    : current count (always < MODULUS)
//   up   : direction, UP = increment, DOWN = decrement
//   nxt  : count after one step, wrapped into 0..MODULUS-1
//   wrap : the step crosses the terminal value (MODULUS-1 up, 0 down)
module mod_next
   import counter_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int MODULUS = DEFAULT_MODULUS
) (
   input  logic [WIDTH-1:0] q,
   input  logic             up,
   output logic [WIDTH-1:0] nxt,
   output logic             wrap
);

   // One extra bit so MODULUS = 2**WIDTH is representable and q+1 never aliases.
   localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] LAST    = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);

   logic [WIDTH:0] qx;
   logic [WIDTH:0] inc;
   logic [WIDTH:0] sum;

   always_comb begin
      qx   = {1'b0, q};
      inc  = qx + ONE;
      sum  = qx;
      wrap = 1'b0;
      if (up == UP) begin
         if (inc == MOD_EXT) begin
            sum  = '0;
            wrap = 1'b1;
         end else begin
            sum  = inc;
         end
      end else begin
         if (qx == '0) begin
            sum  = LAST;
            wrap = 1'b1;
         end else begin
            sum  = qx - ONE;
         end
      end
      nxt = WIDTH'(sum);
   end

endmodule : mod_next

// File: rtl/mod_counter.sv
// mod_counter -- registered modulo-N up/down digit counter with synchronous load.
//   Clock   : rising-edge clock
//   Reset   : synchronous active-high reset
//   Load    : load D this edge (wins over Enable)
//   D       : load value; D >= MODULUS loads 0 and flags LoadErr
//   Enable  : count enable / carry-borrow in from the previous digit
//   Up      : 1 = count up, 0 = count down
//   Q       : registered count, always < MODULUS
//   Cout    : combinational terminal-count carry/borrow out to next digit
//   Wrap    : registered one-cycle pulse after a wrap-around
//   LoadErr : registered one-cycle pulse after an out-of-range load
module mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int MODULUS = DEFAULT_MODULUS
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   input  logic             Enable,
   input  logic             Up,
   output logic [WIDTH-1:0] Q,
   output logic             Cout,
   output logic             Wrap,
   output logic             LoadErr
);

   if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("mod_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
   end

   localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);

   logic [WIDTH-1:0] nxt;
   logic             at_term;
   logic             load_ok;

   mod_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .q    (Q),
      .up   (Up),
      .nxt  (nxt),
      .wrap (at_term)
   );

   assign load_ok = ({1'b0, D} < MOD_EXT);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         Q       <= '0;
         Wrap    <= 1'b0;
         LoadErr <= 1'b0;
      end else if (Load) begin
         Q       <= load_ok ? D : '0;
         Wrap    <= 1'b0;
         LoadErr <= ~load_ok;
      end else if (Enable) begin
         Q       <= nxt;
         Wrap    <= at_term;
         LoadErr <= 1'b0;
      end else begin
         Wrap    <= 1'b0;
         LoadErr <= 1'b0;
      end
   end

   // at_term already encodes (Up ? Q==MODULUS-1 : Q==0) for the current Q.
   assign Cout = ~Reset & Enable & ~Load & at_term;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
module tb_mod_counter;
   import counter_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- BCD digit (table-driven, scoreboarded) ----------------
   logic       b_rst, b_load, b_en, b_up;
   logic [3:0] b_d, b_q;
   logic       b_cout, b_wrap, b_lerr;

   mod_counter #(.WIDTH(4), .MODULUS(BCD_MODULUS)) u_bcd (
      .Clock(clk), .Reset(b_rst), .Load(b_load), .D(b_d), .Enable(b_en), .Up(b_up),
      .Q(b_q), .Cout(b_cout), .Wrap(b_wrap), .LoadErr(b_lerr));

   // ---------------- two-digit BCD cascade ----------------
   logic       c_rst, c_load, c_en, c_up;
   logic [3:0] c_d0, c_d1, c_q0, c_q1;
   logic       c_cout0, c_cout1, c_wrap0, c_wrap1, c_lerr0, c_lerr1;

   mod_counter #(.WIDTH(4), .MODULUS(10)) u_dig0 (
      .Clock(clk), .Reset(c_rst), .Load(c_load), .D(c_d0), .Enable(c_en), .Up(c_up),
      .Q(c_q0), .Cout(c_cout0), .Wrap(c_wrap0), .LoadErr(c_lerr0));

   mod_counter #(.WIDTH(4), .MODULUS(10)) u_dig1 (
      .Clock(clk), .Reset(c_rst), .Load(c_load), .D(c_d1), .Enable(c_cout0), .Up(c_up),
      .Q(c_q1), .Cout(c_cout1), .Wrap(c_wrap1), .LoadErr(c_lerr1));

   // ---------------- hex digit (MODULUS = 2**WIDTH) ----------------
   logic       h_rst, h_load, h_en, h_up;
   logic [3:0] h_d, h_q;
   logic       h_cout, h_wrap, h_lerr;

   mod_counter #(.WIDTH(4), .MODULUS(HEX_MODULUS)) u_hex (
      .Clock(clk), .Reset(h_rst), .Load(h_load), .D(h_d), .Enable(h_en), .Up(h_up),
      .Q(h_q), .Cout(h_cout), .Wrap(h_wrap), .LoadErr(h_lerr));

   // ---------------- modulo-2, one bit ----------------
   logic       m_rst, m_load, m_en, m_up;
   logic [0:0] m_d, m_q;
   logic       m_cout, m_wrap, m_lerr;

   mod_counter #(.WIDTH(1), .MODULUS(2)) u_m2 (
      .Clock(clk), .Reset(m_rst), .Load(m_load), .D(m_d), .Enable(m_en), .Up(m_up),
      .Q(m_q), .Cout(m_cout), .Wrap(m_wrap), .LoadErr(m_lerr));

   // ---------------- vector table and scoreboard ----------------
   typedef struct {
      logic       rst, load;
      logic [3:0] d;
      logic       en, up;
      logic       cout;      // expected before the edge
      logic [3:0] q;         // expected after the edge
      logic       wrap, lerr;
   } vec_t;

   typedef struct {
      int         idx;
      logic [3:0] q;
      logic       wrap, lerr;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   bit   sb_on = 1'b0;

   function automatic void add(input logic rst, input logic load, input logic [3:0] d,
                               input logic en, input logic up, input logic cout,
                               input logic [3:0] q, input logic wrap, input logic lerr);
      vec_t v;
      v.rst = rst; v.load = load; v.d = d; v.en = en; v.up = up;
      v.cout = cout; v.q = q; v.wrap = wrap; v.lerr = lerr;
      vecs.push_back(v);
   endfunction

   // Scoreboard consumer: compare registered outputs 1 time unit after each edge.
   always @(posedge clk) begin
      #1;
      if (sb_on && sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk($sformatf("v%0d Q", e.idx), b_q, e.q);
         chk($sformatf("v%0d Wrap", e.idx), b_wrap, e.wrap);
         chk($sformatf("v%0d LoadErr", e.idx), b_lerr, e.lerr);
      end
   end

   int w0_cnt, w1_cnt;

   initial begin
      {b_rst, b_load, b_en, b_up, b_d} = '0;
      {c_rst, c_load, c_en, c_up, c_d0, c_d1} = '0;
      {h_rst, h_load, h_en, h_up, h_d} = '0;
      {m_rst, m_load, m_en, m_up, m_d} = '0;

      //   rst load  d en up | cout   q wrap lerr
      add(1, 1,  5, 1, 1,    0,     0, 0, 0);   // reset beats load+enable
      add(0, 0,  0, 1, 1,    0,     1, 0, 0);   // BCD up-count 12 edges
      add(0, 0,  0, 1, 1,    0,     2, 0, 0);
      add(0, 0,  0, 1, 1,    0,     3, 0, 0);
      add(0, 0,  0, 1, 1,    0,     4, 0, 0);
      add(0, 0,  0, 1, 1,    0,     5, 0, 0);
      add(0, 0,  0, 1, 1,    0,     6, 0, 0);
      add(0, 0,  0, 1, 1,    0,     7, 0, 0);
      add(0, 0,  0, 1, 1,    0,     8, 0, 0);
      add(0, 0,  0, 1, 1,    0,     9, 0, 0);
      add(0, 0,  0, 1, 1,    1,     0, 1, 0);   // 9 -> 0 wraps
      add(0, 0,  0, 1, 1,    0,     1, 0, 0);
      add(0, 0,  0, 1, 1,    0,     2, 0, 0);
      add(0, 0,  0, 1, 0,    0,     1, 0, 0);   // count down
      add(0, 0,  0, 1, 0,    0,     0, 0, 0);
      add(0, 0,  0, 1, 0,    1,     9, 1, 0);   // 0 -> 9 wraps
      add(0, 0,  0, 1, 0,    0,     8, 0, 0);
      add(0, 0,  0, 0, 1,    0,     8, 0, 0);   // hold
      add(0, 1, 12, 1, 1,    0,     0, 0, 1);   // out-of-range load
      add(0, 0,  0, 0, 0,    0,     0, 0, 0);   // LoadErr lasts one cycle
      add(0, 1,  7, 0, 0,    0,     7, 0, 0);
      add(0, 1,  9, 0, 1,    0,     9, 0, 0);
      add(0, 1,  3, 1, 1,    0,     3, 0, 0);   // load wins at Q=9, no Cout
      add(0, 1, 15, 0, 0,    0,     0, 0, 1);
      add(0, 1,  9, 0, 0,    0,     9, 0, 0);   // good load clears LoadErr
      add(0, 0,  0, 1, 1,    1,     0, 1, 0);
      add(1, 0,  0, 1, 1,    0,     0, 0, 0);   // reset clears pending Wrap
      add(0, 1, 10, 0, 0,    0,     0, 0, 1);   // D == MODULUS is out of range
      add(1, 1,  5, 1, 0,    0,     0, 0, 0);   // reset clears pending LoadErr
      add(0, 0,  0, 1, 0,    1,     9, 1, 0);   // after reset, down: Cout=1
      add(0, 0,  0, 1, 1,    1,     0, 1, 0);   // direction change, back-to-back wrap
      add(0, 0,  0, 1, 0,    1,     9, 1, 0);
      add(0, 1,  0, 1, 0,    0,     0, 0, 0);
      add(1, 0,  0, 1, 0,    0,     0, 0, 0);   // Cout forced low during reset
      add(0, 0,  0, 0, 0,    0,     0, 0, 0);

      sb_on = 1'b1;
      foreach (vecs[i]) begin
         exp_t e;
         @(negedge clk);
         b_rst = vecs[i].rst; b_load = vecs[i].load; b_d = vecs[i].d;
         b_en  = vecs[i].en;  b_up   = vecs[i].up;
         #1;
         chk($sformatf("v%0d Cout", i), b_cout, vecs[i].cout);
         e.idx = i; e.q = vecs[i].q; e.wrap = vecs[i].wrap; e.lerr = vecs[i].lerr;
         sb.push_back(e);
      end
      @(posedge clk); #2;
      sb_on = 1'b0;
      chk("scoreboard drained", sb.size(), 0);

      // ---- two-digit cascade: 98 -> 99 -> 00 -> 01 ----
      @(negedge clk); c_rst = 1'b1;
      @(negedge clk); c_rst = 1'b0; c_load = 1'b1; c_d0 = 4'd8; c_d1 = 4'd9;
      @(negedge clk); c_load = 1'b0; c_en = 1'b1; c_up = 1'b1;
      chk("casc start q1", c_q1, 9);
      chk("casc start q0", c_q0, 8);
      w0_cnt = 0; w1_cnt = 0;
      #1 chk("casc e1 cout0", c_cout0, 0);
      @(posedge clk); #1;
      chk("casc e1 q", {c_q1, c_q0}, 8'h99);
      w0_cnt += int'(c_wrap0); w1_cnt += int'(c_wrap1);
      @(negedge clk); #1;
      chk("casc e2 cout0", c_cout0, 1);
      chk("casc e2 cout1", c_cout1, 1);
      @(posedge clk); #1;
      chk("casc e2 q", {c_q1, c_q0}, 8'h00);
      chk("casc e2 wrap1", c_wrap1, 1);
      w0_cnt += int'(c_wrap0); w1_cnt += int'(c_wrap1);
      @(negedge clk); #1;
      chk("casc e3 cout0", c_cout0, 0);
      @(posedge clk); #1;
      chk("casc e3 q", {c_q1, c_q0}, 8'h01);
      w0_cnt += int'(c_wrap0); w1_cnt += int'(c_wrap1);
      chk("casc wrap0 pulses", w0_cnt, 1);
      chk("casc wrap1 pulses", w1_cnt, 1);
      @(negedge clk); c_en = 1'b0;

      // ---- hex digit: full 4-bit range, no aliasing ----
      @(negedge clk); h_rst = 1'b1;
      @(negedge clk); h_rst = 1'b0; h_load = 1'b1; h_d = 4'd15;
      @(posedge clk); #1;
      chk("hex load15 q", h_q, 15);
      chk("hex load15 err", h_lerr, 0);
      @(negedge clk); h_load = 1'b0; h_en = 1'b1; h_up = 1'b1;
      #1 chk("hex up cout", h_cout, 1);
      @(posedge clk); #1;
      chk("hex up q", h_q, 0);
      chk("hex up wrap", h_wrap, 1);
      @(negedge clk); h_up = 1'b0;
      #1 chk("hex down cout", h_cout, 1);
      @(posedge clk); #1;
      chk("hex down q", h_q, 15);
      chk("hex down wrap", h_wrap, 1);
      @(negedge clk); #1;
      chk("hex 15 down cout", h_cout, 0);
      @(posedge clk); #1;
      chk("hex 14 q", h_q, 14);
      chk("hex 14 wrap", h_wrap, 0);
      @(negedge clk); h_en = 1'b0;

      // ---- modulo-2: continuous up, then alternating direction ----
      @(negedge clk); m_rst = 1'b1;
      @(negedge clk); m_rst = 1'b0; m_en = 1'b1; m_up = 1'b1;
      for (int unsigned k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk($sformatf("m2 up%0d q", k), m_q, (k % 2 == 0) ? 1 : 0);
         chk($sformatf("m2 up%0d wrap", k), m_wrap, (k % 2 == 0) ? 0 : 1);
      end
      // Q is 0 now; down wraps to 1, up wraps to 0, repeatedly.
      for (int unsigned k = 0; k < 4; k++) begin
         @(negedge clk); m_up = (k % 2 == 0) ? DOWN : UP;
         @(posedge clk); #1;
         chk($sformatf("m2 alt%0d q", k), m_q, (k % 2 == 0) ? 1 : 0);
         chk($sformatf("m2 alt%0d wrap", k), m_wrap, 1);
      end
      @(negedge clk); m_en = 1'b0;
      @(posedge clk); #1;
      chk("m2 hold wrap", m_wrap, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard cap so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_mod_counter

// File: doc/mod_counter.md
# mod_counter

Registered modulo-N up/down digit counter with synchronous load. It is the sequential stage directly upstream of the `RCA` incrementer: its `Q` drives the 4-bit `X` operand, and its combinational `Cout` drives the next digit's `Enable` and the `RCA` `Carry`. Stages cascade into multi-digit BCD or binary counters. Default configuration is one BCD digit (WIDTH=4, MODULUS=10).

## Interface
- `WIDTH`, default 4: counter and load-data width in bits.
- `MODULUS`, default 10: count range is 0 to MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2**WIDTH; anything else is an elaboration error.
- `Clock` input 1: single clock, rising edge.
- `Reset` input 1: synchronous, active-high. It is sampled only on a rising `Clock` edge.
- `Load` input 1: synchronous load of `D`.
- `D` input WIDTH: load value.
- `Enable` input 1: count enable; this is also the carry/borrow-in from the previous digit.
- `Up` input 1: direction, 1 = increment, 0 = decrement.
- `Q` output WIDTH: registered count.
- `Cout` output 1: combinational terminal-count carry/borrow-out to the next digit.
- `Wrap` output 1: registered one-cycle pulse, asserted after a wrap-around.
- `LoadErr` output 1: registered one-cycle pulse, asserted after an out-of-range load.

## Operation
- Priority at each rising edge: Reset > Load > Enable > hold.
- **Reset:** `Q`=0, `Wrap`=0, `LoadErr`=0.
- **Load, D < MODULUS:** `Q`=`D`, `LoadErr`=0.
- **Load, D ≥ MODULUS:** `Q`=0, `LoadErr`=1.
- **Load cycles:** `Enable` and `Up` are ignored and `Wrap`=0.
- **Enable with Up=1:**
  - If `Q`==MODULUS-1, then `Q`=0 and `Wrap`=1.
  - Otherwise `Q`=`Q`+1 and `Wrap`=0.
- **Enable with Up=0:**
  - If `Q`==0, then `Q`=MODULUS-1 and `Wrap`=1.
  - Otherwise `Q`=`Q`-1 and `Wrap`=0.
- **Hold** (no Reset, Load or Enable): `Q` unchanged, `Wrap`=0, `LoadErr`=0.
- **Cout** = `Enable` & ~`Load` & (`Up` ? `Q`==MODULUS-1 : `Q`==0). It is purely combinational from the current `Q` and the inputs, and is forced to 0 while `Reset` is high.
- **Invariant:** `Q` < MODULUS on every cycle. An out-of-range value is never stored.
- **Arithmetic:** compute in WIDTH+1 bits and compare against MODULUS before truncating, so MODULUS = 2**WIDTH wraps naturally with no overflow aliasing.
- **Direction change** is allowed on any cycle. It takes effect on the same edge with no turnaround cycle.

## Timing
- `Q`, `Wrap`, `LoadErr`: one-cycle latency from the sampling edge. All three are glitch-free register outputs.
- `Cout`: zero latency (same cycle), so an N-digit cascade advances all digits on one edge. The ripple path is N × (compare + AND).
- **Reset values:**
  - `Q`=0, `Wrap`=0, `LoadErr`=0.
  - `Cout` is 0 during Reset.
  - After Reset, with `Enable`=1 and `Up`=0, `Cout`=1 (at 0, counting down).
- **Reset mid-operation:** overrides a simultaneous `Load` or `Enable` on the same edge, and any pending `Wrap`/`LoadErr` pulse is cleared.
- **Load and Enable on the same edge:** the load wins. No wrap occurs, and `Cout`=0 that cycle, so the next digit does not step.
- **Back-to-back wraps:** (e.g. MODULUS=2, continuous `Enable`) `Wrap` stays high on consecutive cycles. The pulse is not stretched and not merged.

## Structure
- Shared package `counter_pkg`: default WIDTH/MODULUS constants, BCD_MODULUS=10, HEX_MODULUS=16, and the direction encoding constants UP=1, DOWN=0.
- Sub-module `mod_next` (combinational): maps `Q`, `Up` to the next value and a wrap flag. It holds the WIDTH+1 arithmetic and compares.
- Top level: the priority mux, the `Q`/`Wrap`/`LoadErr` registers, and the `Cout` logic.

## Test plan
- **Reset:** `Reset`=1 with `Load`=1, `D`=5, `Enable`=1 → next cycle `Q`=0, `Wrap`=0, `LoadErr`=0, and `Cout`=0 while `Reset` is high.
- **BCD up-count:** `Enable`=1, `Up`=1 from 0 for 12 edges → `Q` sequence 1..9,0,1,2. `Cout`=1 only in the cycle `Q`=9. `Wrap`=1 only in the cycle after `Q` goes 9→0.
- **Down-count wrap:** `Enable`=1, `Up`=0 from `Q`=0 → next `Q`=9 with `Wrap`=1. `Cout`=1 in the `Q`=0 cycle.
- **Out-of-range load:**
  - `Load`=1, `D`=12 (MODULUS=10) → `Q`=0, `LoadErr`=1 for exactly one cycle.
  - `D`=7 → `Q`=7, `LoadErr`=0.
- **Simultaneous load and count:** `Q`=9, `Load`=1, `D`=3, `Enable`=1, `Up`=1 → `Q`=3, `Wrap`=0, `Cout`=0.
- **Two-digit cascade** (digit0 `Cout` → digit1 `Enable`): start at 98, count up 3 edges → 99, 00, 01. Digit1 wraps 9→0 on the same edge as digit0, and each digit's `Wrap` pulses once.
